aclk_areg_bank: RTL and testbench

- Multi-slot successor to the single alarm register: holds NUM_ALARMS BCD alarm times (HH:MM, 24 h), each with its own enable bit.
- Compares enabled slots against the running clock time once per minute tick.
- Drives the sound request through a ring/snooze/stop state machine.
- Sits between the time counter (supplies current time and min_tick) and the display/buzzer logic.

---
 rtl/aclk_areg_bank.sv | 200 ++++++++++++++++++++
 tb/tb_aclk_areg_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_areg_bank.sv
// Multi-slot BCD alarm register bank with a ring/snooze/stop sequencer.
// Slots are compared against the running time once per minute tick.
module aclk_areg_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3,
    parameter int RING_MIN   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_new_a,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
    input  logic                  en_we,
    input  logic                  en_val,
    input  logic [3:0]            cur_ms_hr,
    input  logic [3:0]            cur_ls_hr,
    input  logic [3:0]            cur_ms_min,
    input  logic [3:0]            cur_ls_min,
    input  logic                  min_tick,
    input  logic                  snooze,
    input  logic                  stop_alarm,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [3:0]            alarm_time_ms_hr,
    output logic [3:0]            alarm_time_ls_hr,
    output logic [3:0]            alarm_time_ms_min,
    output logic [3:0]            alarm_time_ls_min,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic                  sound_alarm,
    output logic                  alarm_busy,
    output logic [IDX_W-1:0]      alarm_src,
    output logic [2:0]            snooze_left,
    output logic                  load_err
);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    localparam logic [2:0] MAX_L = 3'(MAX_SNOOZE);
    localparam logic [3:0] SNZ_L = 4'(SNOOZE_MIN);
    localparam logic [3:0] RNG_L = 4'(RING_MIN);

    state_t     state;
    logic [3:0] ring_cnt;
    logic [3:0] snz_cnt;

    logic [3:0] s_mh [NUM_ALARMS];
    logic [3:0] s_lh [NUM_ALARMS];
    logic [3:0] s_mm [NUM_ALARMS];
    logic [3:0] s_lm [NUM_ALARMS];

    logic             time_ok;
    logic             idx_ok;
    logic             load_ok;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             dis_src;

    always_comb begin
        time_ok = !((new_alarm_ms_hr > 4'd2) ||
                    (new_alarm_ls_hr > 4'd9) ||
                    (new_alarm_ms_hr == 4'd2 && new_alarm_ls_hr > 4'd3) ||
                    (new_alarm_ms_min > 4'd5) ||
                    (new_alarm_ls_min > 4'd9));
        idx_ok = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (load_idx == IDX_W'(i)) idx_ok = 1'b1;
        end
        load_ok = time_ok && idx_ok;
        dis_src = en_we && !en_val && (load_idx == alarm_src);
    end

    // Descending scan so the lowest enabled matching slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] &&
                s_mh[i] == cur_ms_hr && s_lh[i] == cur_ls_hr &&
                s_mm[i] == cur_ms_min && s_lm[i] == cur_ls_min) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        alarm_time_ms_hr  = '0;
        alarm_time_ls_hr  = '0;
        alarm_time_ms_min = '0;
        alarm_time_ls_min = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                alarm_time_ms_hr  = s_mh[i];
                alarm_time_ls_hr  = s_lh[i];
                alarm_time_ms_min = s_mm[i];
                alarm_time_ls_min = s_lm[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                s_mh[i] <= '0;
                s_lh[i] <= '0;
                s_mm[i] <= '0;
                s_lm[i] <= '0;
            end
            alarm_en <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_new_a && !load_ok;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (load_idx == IDX_W'(i)) begin
                    if (load_new_a && time_ok) begin
                        s_mh[i] <= new_alarm_ms_hr;
                        s_lh[i] <= new_alarm_ls_hr;
                        s_mm[i] <= new_alarm_ms_min;
                        s_lm[i] <= new_alarm_ls_min;
                    end
                    if (en_we) alarm_en[i] <= en_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sound_alarm <= 1'b0;
            alarm_busy  <= 1'b0;
            alarm_src   <= '0;
            snooze_left <= '0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (min_tick && hit) begin
                        state       <= RINGING;
                        sound_alarm <= 1'b1;
                        alarm_busy  <= 1'b1;
                        alarm_src   <= hit_idx;
                        snooze_left <= MAX_L;
                        ring_cnt    <= '0;
                    end
                end
                RINGING: begin
                    if (stop_alarm || dis_src) begin
                        state       <= IDLE;
                        sound_alarm <= 1'b0;
                        alarm_busy  <= 1'b0;
                        snooze_left <= '0;
                    end else if (snooze && snooze_left != 3'd0) begin
                        state       <= SNOOZED;
                        sound_alarm <= 1'b0;
                        snz_cnt     <= SNZ_L;
                        snooze_left <= snooze_left - 3'd1;
                    end else if (min_tick) begin
                        if (ring_cnt + 4'd1 == RNG_L) begin
                            state       <= IDLE;
                            sound_alarm <= 1'b0;
                            alarm_busy  <= 1'b0;
                            snooze_left <= '0;
                        end else begin
                            ring_cnt <= ring_cnt + 4'd1;
                        end
                    end
                end
                SNOOZED: begin
                    if (stop_alarm || dis_src) begin
                        state       <= IDLE;
                        sound_alarm <= 1'b0;
                        alarm_busy  <= 1'b0;
                        snooze_left <= '0;
                    end else if (min_tick) begin
                        if (snz_cnt == 4'd1) begin
                            state       <= RINGING;
                            sound_alarm <= 1'b1;
                            ring_cnt    <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    sound_alarm <= 1'b0;
                    alarm_busy  <= 1'b0;
                    snooze_left <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_areg_bank.sv
// Directed bench for aclk_areg_bank: load table plus ring/snooze sequences.
// Uses a 3-bit slot index so an out-of-range slot can be addressed.
module tb_aclk_areg_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_new_a = 1'b0;
    logic [2:0] load_idx = '0;
    logic [3:0] n_mh = '0, n_lh = '0, n_mm = '0, n_lm = '0;
    logic       en_we = 1'b0;
    logic       en_val = 1'b0;
    logic [3:0] c_mh = '0, c_lh = '0, c_mm = '0, c_lm = '0;
    logic       min_tick = 1'b0;
    logic       snooze = 1'b0;
    logic       stop_alarm = 1'b0;
    logic [2:0] rd_idx = '0;
    logic [3:0] a_mh, a_lh, a_mm, a_lm;
    logic [3:0] alarm_en;
    logic       sound_alarm, alarm_busy, load_err;
    logic [2:0] alarm_src;
    logic [2:0] snooze_left;

    int n_cmp = 0;
    int n_bad = 0;

    aclk_areg_bank #(
        .NUM_ALARMS(4), .IDX_W(3), .SNOOZE_MIN(5),
        .MAX_SNOOZE(3), .RING_MIN(2)
    ) dut (
        .clk(clk), .reset(reset),
        .load_new_a(load_new_a), .load_idx(load_idx),
        .new_alarm_ms_hr(n_mh), .new_alarm_ls_hr(n_lh),
        .new_alarm_ms_min(n_mm), .new_alarm_ls_min(n_lm),
        .en_we(en_we), .en_val(en_val),
        .cur_ms_hr(c_mh), .cur_ls_hr(c_lh),
        .cur_ms_min(c_mm), .cur_ls_min(c_lm),
        .min_tick(min_tick), .snooze(snooze), .stop_alarm(stop_alarm),
        .rd_idx(rd_idx),
        .alarm_time_ms_hr(a_mh), .alarm_time_ls_hr(a_lh),
        .alarm_time_ms_min(a_mm), .alarm_time_ls_min(a_lm),
        .alarm_en(alarm_en), .sound_alarm(sound_alarm),
        .alarm_busy(alarm_busy), .alarm_src(alarm_src),
        .snooze_left(snooze_left), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] t;
        logic        exp_err;
        logic [2:0]  rd;
        logic [15:0] exp_rd;
    } load_vec_t;

    load_vec_t vec [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [15:0] t);
        {c_mh, c_lh, c_mm, c_lm} = t;
        min_tick = 1'b1;
        cyc();
        min_tick = 1'b0;
    endtask

    task automatic set_en(input logic [2:0] idx, input logic v);
        load_idx = idx;
        en_val = v;
        en_we = 1'b1;
        cyc();
        en_we = 1'b0;
    endtask

    task automatic read_slot(input logic [2:0] idx, output logic [15:0] t);
        rd_idx = idx;
        #1;
        t = {a_mh, a_lh, a_mm, a_lm};
    endtask

    initial begin
        logic [15:0] rt;

        vec[0]  = '{3'd1, 16'h1234, 1'b0, 3'd1, 16'h1234};
        vec[1]  = '{3'd2, 16'h2345, 1'b0, 3'd2, 16'h2345};
        vec[2]  = '{3'd1, 16'h2400, 1'b1, 3'd1, 16'h1234};
        vec[3]  = '{3'd2, 16'h1960, 1'b1, 3'd2, 16'h2345};
        vec[4]  = '{3'd5, 16'h0100, 1'b1, 3'd0, 16'h0000};
        vec[5]  = '{3'd0, 16'h3000, 1'b1, 3'd0, 16'h0000};
        vec[6]  = '{3'd3, 16'h0959, 1'b0, 3'd3, 16'h0959};
        vec[7]  = '{3'd3, 16'h000A, 1'b1, 3'd3, 16'h0959};
        vec[8]  = '{3'd0, 16'h2359, 1'b0, 3'd0, 16'h2359};
        vec[9]  = '{3'd1, 16'h0730, 1'b0, 3'd1, 16'h0730};
        vec[10] = '{3'd3, 16'h0730, 1'b0, 3'd3, 16'h0730};

        {c_mh, c_lh, c_mm, c_lm} = 16'h0800;
        #12;
        chk("rst_sound", sound_alarm, 0);
        chk("rst_busy", alarm_busy, 0);
        chk("rst_src", alarm_src, 0);
        chk("rst_snz_left", snooze_left, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_en", alarm_en, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        foreach (vec[k]) begin
            load_idx = vec[k].idx;
            {n_mh, n_lh, n_mm, n_lm} = vec[k].t;
            load_new_a = 1'b1;
            cyc();
            load_new_a = 1'b0;
            chk($sformatf("load_err[%0d]", k), load_err, vec[k].exp_err);
            read_slot(vec[k].rd, rt);
            chk($sformatf("readback[%0d]", k), rt, vec[k].exp_rd);
            cyc();
            chk($sformatf("err_clear[%0d]", k), load_err, 0);
        end
        chk("en_after_loads", alarm_en, 4'b0000);
        read_slot(3'd2, rt);
        chk("slot2_kept", rt, 16'h2345);

        set_en(3'd1, 1'b1);
        set_en(3'd3, 1'b1);
        set_en(3'd5, 1'b1);
        chk("en_vec", alarm_en, 4'b1010);
        chk("en_oob_no_err", load_err, 0);

        tick(16'h0730);
        chk("trig_sound", sound_alarm, 1);
        chk("trig_busy", alarm_busy, 1);
        chk("trig_src", alarm_src, 1);
        chk("trig_left", snooze_left, 3);

        for (int s = 0; s < 3; s++) begin
            snooze = 1'b1;
            cyc();
            snooze = 1'b0;
            chk($sformatf("snz%0d_sound", s), sound_alarm, 0);
            chk($sformatf("snz%0d_busy", s), alarm_busy, 1);
            chk($sformatf("snz%0d_left", s), snooze_left, 32'(2 - s));
            for (int t = 0; t < 4; t++) begin
                tick(t == 0 ? 16'h0730 : 16'h0801);
                chk($sformatf("snz%0d_t%0d", s, t), sound_alarm, 0);
            end
            chk($sformatf("snz%0d_src", s), alarm_src, 1);
            tick(16'h0805);
            chk($sformatf("snz%0d_wake", s), sound_alarm, 1);
        end

        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        chk("snz4_ignored", sound_alarm, 1);
        chk("snz4_left", snooze_left, 0);
        tick(16'h0820);
        chk("auto_t1_sound", sound_alarm, 1);
        tick(16'h0821);
        chk("auto_t2_sound", sound_alarm, 0);
        chk("auto_t2_busy", alarm_busy, 0);
        chk("auto_src_hold", alarm_src, 1);
        chk("auto_left", snooze_left, 0);

        tick(16'h0730);
        chk("retrig_sound", sound_alarm, 1);
        snooze = 1'b1;
        stop_alarm = 1'b1;
        cyc();
        snooze = 1'b0;
        stop_alarm = 1'b0;
        chk("stopwin_sound", sound_alarm, 0);
        chk("stopwin_busy", alarm_busy, 0);
        chk("stopwin_left", snooze_left, 0);

        tick(16'h0730);
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        chk("dis_pre_busy", alarm_busy, 1);
        set_en(3'd1, 1'b0);
        chk("dis_busy", alarm_busy, 0);
        chk("dis_sound", sound_alarm, 0);
        chk("dis_en", alarm_en, 4'b1000);

        tick(16'h0730);
        chk("low_idx_src", alarm_src, 3);
        chk("low_idx_sound", sound_alarm, 1);

        #2;
        reset = 1'b0;
        #1;
        chk("arst_sound", sound_alarm, 0);
        chk("arst_busy", alarm_busy, 0);
        chk("arst_src", alarm_src, 0);
        chk("arst_left", snooze_left, 0);
        chk("arst_en", alarm_en, 0);
        for (int i = 0; i < 4; i++) begin
            read_slot(3'(i), rt);
            chk($sformatf("arst_slot%0d", i), rt, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
